logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter.sv | 151 +++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter in front of a bitwise logic unit.
// One operation in flight at a time: IDLE accepts, EXEC computes, HOLD presents the result.
module logic_unit_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  input  logic             res_ready,
  output logic             busy,
  output logic [15:0]      ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               id_q, id_d;
  logic               last_q, last_d;
  logic               res_valid_q, res_valid_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;
  logic               res_id_q, res_id_d;
  logic [15:0]        ops_done_q, ops_done_d;

  logic [1:0]             req_valid;
  logic [1:0][1:0]        req_op_v;
  logic [1:0][WIDTH-1:0]  req_a_v;
  logic [1:0][WIDTH-1:0]  req_b_v;
  logic [1:0]             grant;
  logic [1:0]             req_ready;
  logic                   grant_id;
  logic [WIDTH-1:0]       alu_res;

  assign req_valid = {req1_valid, req0_valid};
  assign req_op_v  = {req1_op, req0_op};
  assign req_a_v   = {req1_a, req0_a};
  assign req_b_v   = {req1_b, req0_b};

  // last_q holds the most recent winner; under contention the other side wins.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    localparam int   OTHER    = 1 - gi;
    localparam logic OTHER_ID = 1'(1 - gi);
    assign grant[gi]     = req_valid[gi] && (!req_valid[OTHER] || (last_q == OTHER_ID));
    assign req_ready[gi] = rst && (state_q == IDLE) && grant[gi];
  end

  assign grant_id   = grant[1];
  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign alu_res[gi] = (op_q == OP_AND) ? (a_q[gi] & b_q[gi]) :
                         (op_q == OP_OR)  ? (a_q[gi] | b_q[gi]) :
                         (op_q == OP_XOR) ? (a_q[gi] ^ b_q[gi]) :
                                            ~a_q[gi];
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    last_d      = last_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    ops_done_d  = ops_done_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          op_d    = req_op_v[grant_id];
          a_d     = req_a_v[grant_id];
          b_d     = req_b_v[grant_id];
          id_d    = grant_id;
          last_d  = grant_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = alu_res;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      ops_done_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      last_q      <= last_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign ops_done  = ops_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed results.
module tb_logic_unit_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0]   req0_op = 2'b00, req1_op = 2'b00;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         res_ready = 1'b1;
  logic         req0_ready, req1_ready, res_valid, res_id, busy;
  logic [W-1:0] res_data;
  logic [15:0]  ops_done;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  bit preload = 1'b0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
    .busy(busy), .ops_done(ops_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [W-1:0] op_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // bit N set = requester N wins; contention goes to whoever did not win last
  function automatic logic [1:0] grant_of(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  logic         m_busy = 1'b0, m_shown = 1'b0, m_last = 1'b1, m_id = 1'b0;
  logic         m_res_valid = 1'b0, m_res_id = 1'b0;
  logic [W-1:0] m_res_data = '0, m_pend = '0;
  logic [15:0]  m_ops = 16'd0;
  logic [1:0]   m_grant, exp_ready;

  assign m_grant   = grant_of(req0_valid, req1_valid, m_last);
  assign exp_ready = (rst && !m_busy) ? m_grant : 2'b00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_shown <= 1'b0; m_last <= 1'b1;
      m_res_valid <= 1'b0; m_res_data <= '0; m_res_id <= 1'b0; m_ops <= 16'd0;
    end else begin
      if (preload) m_ops <= 16'hFFFF;
      if (!m_busy) begin
        if (m_grant != 2'b00) begin
          m_id    <= m_grant[1];
          m_last  <= m_grant[1];
          m_pend  <= m_grant[1] ? op_result(req1_op, req1_a, req1_b) : op_result(req0_op, req0_a, req0_b);
          m_busy  <= 1'b1;
          m_shown <= 1'b0;
        end
      end else if (!m_shown) begin
        m_res_valid <= 1'b1;
        m_res_data  <= m_pend;
        m_res_id    <= m_id;
        m_shown     <= 1'b1;
      end else if (res_ready) begin
        m_res_valid <= 1'b0;
        m_ops       <= m_ops + 16'd1;
        m_busy      <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_req0_ready", req0_ready, exp_ready[0]);
      chk("cyc_req1_ready", req1_ready, exp_ready[1]);
      chk("cyc_res_valid", res_valid, m_res_valid);
      chk("cyc_res_data", res_data, m_res_data);
      chk("cyc_res_id", res_id, m_res_id);
      chk("cyc_busy", busy, m_busy);
      if (!preload) chk("cyc_ops_done", ops_done, m_ops);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for whichever request is accepted, drops that valid after the accept edge.
  task automatic serve(output int who);
    logic r0, r1;
    who = -1;
    for (int k = 0; k < 20; k++) begin
      #1;
      r0 = req0_ready;
      r1 = req1_ready;
      @(posedge clk);
      #1;
      if (r0) begin req0_valid = 1'b0; who = 0; break; end
      if (r1) begin req1_valid = 1'b0; who = 1; break; end
    end
    if (who < 0) begin
      checks++; failures++;
      $display("FAIL serve_timeout actual=none required=accept");
    end
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!busy) begin idle = 1'b1; break; end
      step();
    end
    chk("drain_idle", idle, 1'b1);
  endtask

  initial begin
    int who;
    // reset state; a valid during reset must not see ready
    req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    #1;
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 16'h0000);
    chk("rst_ops_done", ops_done, 16'h0000);
    req0_valid = 1'b0;
    step(); rst = 1'b1; step();

    // single NOT from req0, latency of two edges from accept
    req0_op = 2'b11; req0_a = 16'h000B; req0_b = 16'h1234; req0_valid = 1'b1;
    serve(who);
    chk("t1_grant", who, 0);
    chk("t1_exec_res_valid", res_valid, 1'b0);
    step();
    chk("t1_res_valid", res_valid, 1'b1);
    chk("t1_res_data", res_data, 16'hFFF4);
    chk("t1_res_id", res_id, 1'b0);
    step();
    chk("t1_ops_done", ops_done, 16'd1);
    chk("t1_idle", busy, 1'b0);

    // contention from reset, round robin
    rst = 1'b0; step(); rst = 1'b1; step();
    req0_op = 2'b00; req0_a = 16'hF00F; req0_b = 16'h0FF0;
    req1_op = 2'b01; req1_a = 16'hF000; req1_b = 16'h000F;
    req0_valid = 1'b1; req1_valid = 1'b1;
    serve(who);
    chk("t2_first_grant", who, 0);
    step();
    chk("t2_first_data", res_data, 16'h0000);
    chk("t2_first_id", res_id, 1'b0);
    serve(who);
    chk("t2_second_grant", who, 1);
    step();
    chk("t2_second_data", res_data, 16'hF00F);
    chk("t2_second_id", res_id, 1'b1);
    req0_op = 2'b10; req0_a = 16'h00FF; req0_b = 16'h0F0F;
    req1_op = 2'b11; req1_a = 16'h1234; req1_b = 16'hFFFF;
    req0_valid = 1'b1; req1_valid = 1'b1;
    serve(who);
    chk("t2_third_grant", who, 0);
    step();
    chk("t2_third_data", res_data, 16'h0FF0);
    serve(who);
    chk("t2_fourth_grant", who, 1);
    step();
    chk("t2_fourth_data", res_data, 16'hEDCB);
    step();
    drain();
    chk("t2_ops_done", ops_done, 16'd4);

    // stalled consumer: result held, late requester ignored then cancelled
    res_ready = 1'b0;
    req0_op = 2'b10; req0_a = 16'hFFFF; req0_b = 16'hAAAA; req0_valid = 1'b1;
    serve(who);
    step();
    req1_op = 2'b00; req1_a = 16'hFFFF; req1_b = 16'hFFFF; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", res_valid, 1'b1);
      chk("t3_hold_data", res_data, 16'h5555);
      chk("t3_busy", busy, 1'b1);
      chk("t3_req1_ready", req1_ready, 1'b0);
      step();
    end
    req1_valid = 1'b0;
    chk("t3_ops_before", ops_done, 16'd4);
    res_ready = 1'b1;
    step();
    chk("t3_ops_after", ops_done, 16'd5);
    chk("t3_idle", busy, 1'b0);
    chk("t3_res_valid", res_valid, 1'b0);

    // reset during HOLD discards the result
    res_ready = 1'b0;
    req1_op = 2'b01; req1_a = 16'h0F0F; req1_b = 16'hF0F0; req1_valid = 1'b1;
    serve(who);
    chk("t4_grant", who, 1);
    step();
    chk("t4_in_hold", res_valid, 1'b1);
    rst = 1'b0;
    req1_valid = 1'b1;
    #1;
    chk("t4_res_valid", res_valid, 1'b0);
    chk("t4_res_data", res_data, 16'h0000);
    chk("t4_ops_done", ops_done, 16'd0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_req1_ready", req1_ready, 1'b0);
    req1_valid = 1'b0;
    step(); rst = 1'b1; res_ready = 1'b1; step();
    req0_op = 2'b00; req0_a = 16'h0FF0; req0_b = 16'h00FF; req0_valid = 1'b1;
    serve(who);
    chk("t4_after_grant", who, 0);
    step();
    chk("t4_after_data", res_data, 16'h00F0);
    step();
    chk("t4_after_ops", ops_done, 16'd1);

    // counter wrap: park the count at its maximum, then complete one more
    drain();
    preload = 1'b1;
    force dut.ops_done_q = 16'hFFFF;
    step();
    release dut.ops_done_q;
    preload = 1'b0;
    chk("t5_preloaded", ops_done, 16'hFFFF);
    req1_op = 2'b11; req1_a = 16'h0000; req1_b = 16'h5A5A; req1_valid = 1'b1;
    serve(who);
    step();
    chk("t5_data", res_data, 16'hFFFF);
    chk("t5_id", res_id, 1'b1);
    step();
    chk("t5_wrap", ops_done, 16'h0000);
    step();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
